// File: rtl/clksel_pkg.sv
// Shared types and constants for the CPU clock-select sequencer.
package clksel_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    SLOW    = 2'd0,
    TO_FAST = 2'd1,
    FAST    = 2'd2,
    TO_SLOW = 2'd3
  } clk_state_t;

  // Feedback synchronisers come out of reset claiming "on the slow clock".
  localparam logic       HS_S_RST  = 1'b0;
  localparam logic       LS_S_RST  = 1'b1;
  localparam clk_state_t STATE_RST = SLOW;

endpackage

// File: rtl/clksel_sync.sv
// Multi-stage flop synchroniser for one asynchronous feedback bit,
// with a per-instance reset value.
module clksel_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic hsclk_in,
  input  logic rst_b,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples the previous stage's old value on the same edge.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) ff <= {STAGES{RST_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/clksel_seq.sv
// Fast/slow CPU clock sequencer driving the glitch-free clock switcher.
// Optional CLKSEL_STATS_EN adds switch_cnt, a wrapping count of FAST entries.
module clksel_seq
  import clksel_pkg::*;
#(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int SYNC_STAGES    = 2
) (
  input  logic        hsclk_in,
  input  logic        rst_b,
  input  logic        fast_en,
  input  logic        div_sel_req,
  input  logic        slow_req,
  input  logic        err_clr,
  input  logic        hsclk_selected_in,
  input  logic        lsclk_selected_in,
  output logic        hsclk_sel,
  output logic        cpuclk_div_sel,
  output logic        slow_ack,
  output logic        busy,
  output logic        timeout_err
`ifdef CLKSEL_STATS_EN
 ,output logic [15:0] switch_cnt
`endif
);

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] WDOG_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WDOG_PRE  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  clk_state_t       state_q, state_d;
  logic [CNT_W-1:0] hold_q, wdog_q;
  logic             hs_s, ls_s;
  logic             sel_d, div_d, err_d;
  logic             wdog_expire;

  clksel_sync #(.STAGES(SYNC_STAGES), .RST_VAL(HS_S_RST)) u_hs_sync (
    .hsclk_in (hsclk_in),
    .rst_b    (rst_b),
    .d        (hsclk_selected_in),
    .q        (hs_s)
  );

  clksel_sync #(.STAGES(SYNC_STAGES), .RST_VAL(LS_S_RST)) u_ls_sync (
    .hsclk_in (hsclk_in),
    .rst_b    (rst_b),
    .d        (lsclk_selected_in),
    .q        (ls_s)
  );

  assign busy        = (state_q == TO_FAST) || (state_q == TO_SLOW);
  assign slow_ack    = (state_q == SLOW) && ls_s;
  // Fires once, on the cycle the watchdog would step onto its limit.
  assign wdog_expire = busy && (wdog_q == WDOG_PRE);

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    sel_d   = hsclk_sel;
    div_d   = cpuclk_div_sel;
    err_d   = timeout_err && !err_clr;
    unique case (state_q)
      SLOW: begin
        if (fast_en && !slow_req && (hold_q == '0) && ls_s && !hs_s && !timeout_err) begin
          state_d = TO_FAST;
          sel_d   = 1'b1;
          div_d   = div_sel_req;
        end
      end
      TO_FAST: begin
        if (hs_s && !ls_s) begin
          state_d = FAST;
        end else if (wdog_expire) begin
          state_d = TO_SLOW;
          sel_d   = 1'b0;
          err_d   = 1'b1;
        end
      end
      FAST: begin
        if (slow_req || !fast_en) begin
          state_d = TO_SLOW;
          sel_d   = 1'b0;
        end
      end
      TO_SLOW: begin
        // No safer fallback exists: on timeout stay here with the fast clock deselected.
        if (ls_s && !hs_s) state_d = SLOW;
        else if (wdog_expire) err_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b) begin
      state_q        <= STATE_RST;
      hsclk_sel      <= 1'b0;
      cpuclk_div_sel <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      state_q        <= state_d;
      hsclk_sel      <= sel_d;
      cpuclk_div_sel <= div_d;
      timeout_err    <= err_d;
    end
  end

  // Hold-off reloads outside SLOW (covers entry) and while the host is active.
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b)                             hold_q <= HOLD_INIT;
    else if (state_q != SLOW || slow_req)   hold_q <= HOLD_INIT;
    else if (hold_q != '0)                  hold_q <= hold_q - ONE;
  end

  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b)                           wdog_q <= '0;
    else if (state_d != state_q)          wdog_q <= '0;
    else if (busy && wdog_q != WDOG_MAX)  wdog_q <= wdog_q + ONE;
  end

`ifdef CLKSEL_STATS_EN
  always_ff @(posedge hsclk_in or negedge rst_b) begin
    if (!rst_b)                                 switch_cnt <= '0;
    else if (state_d == FAST && state_q != FAST) switch_cnt <= switch_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_clksel_seq.sv
// Directed bench for clksel_seq: stimulus pushes cycle-tagged expectations,
// a negedge monitor pops and compares them against the outputs.
module tb_clksel_seq;

  localparam int SW_DLY = 4;

  logic hsclk_in = 1'b0;
  logic rst_b = 1'b0;
  logic fast_en = 1'b0, div_sel_req = 1'b0, slow_req = 1'b0, err_clr = 1'b0;
  logic hs_in = 1'b0, ls_in = 1'b1;
  logic hsclk_sel, cpuclk_div_sel, slow_ack, busy, timeout_err;
`ifdef CLKSEL_STATS_EN
  logic [15:0] switch_cnt;
`endif

  clksel_seq dut (
    .hsclk_in          (hsclk_in),
    .rst_b             (rst_b),
    .fast_en           (fast_en),
    .div_sel_req       (div_sel_req),
    .slow_req          (slow_req),
    .err_clr           (err_clr),
    .hsclk_selected_in (hs_in),
    .lsclk_selected_in (ls_in),
    .hsclk_sel         (hsclk_sel),
    .cpuclk_div_sel    (cpuclk_div_sel),
    .slow_ack          (slow_ack),
    .busy              (busy),
    .timeout_err       (timeout_err)
`ifdef CLKSEL_STATS_EN
   ,.switch_cnt        (switch_cnt)
`endif
  );

  always #5 hsclk_in = ~hsclk_in;

  int cyc = 0;
  always @(posedge hsclk_in) cyc <= cyc + 1;

  // Switcher model: answers a hsclk_sel change SW_DLY cycles later.
  // In dead mode it drops lsclk_selected but never raises hsclk_selected.
  logic last_sel = 1'b0;
  int   dly = 0;
  bit   dead = 1'b0;

  task automatic sw_apply();
    if (dead) begin
      if (last_sel) ls_in = 1'b0;
    end else begin
      hs_in = last_sel;
      ls_in = !last_sel;
    end
  endtask

  always @(negedge hsclk_in) begin
    if (hsclk_sel !== last_sel) begin
      last_sel = hsclk_sel;
      dly      = SW_DLY;
    end else if (dly > 0) begin
      dly--;
      if (dly == 0) sw_apply();
    end else if (!dead && (hs_in != last_sel || ls_in == last_sel)) begin
      sw_apply();
    end
  end

  // Scoreboard. exp bits: {hsclk_sel, cpuclk_div_sel, slow_ack, busy, timeout_err}.
  typedef struct {
    int         cyc;
    string      name;
    logic [4:0] exp;
    int         cnt;
  } item_t;

  item_t sb[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic expect_now(input string name, input logic [4:0] v, input int cnt = -1);
    item_t it;
    it.cyc  = cyc;
    it.name = name;
    it.exp  = v;
    it.cnt  = cnt;
    sb.push_back(it);
  endtask

  always @(negedge hsclk_in) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      item_t      it;
      logic [4:0] got;
      bit         bad;
      it  = sb.pop_front();
      got = {hsclk_sel, cpuclk_div_sel, slow_ack, busy, timeout_err};
      bad = (it.cyc != cyc) || (got !== it.exp);
`ifdef CLKSEL_STATS_EN
      if (it.cnt >= 0 && switch_cnt !== 16'(it.cnt)) bad = 1'b1;
      if (bad) $display("FAIL %s @cyc %0d: sel/div/ack/busy/err got %b want %b, switch_cnt got %0d want %0d",
                        it.name, cyc, got, it.exp, switch_cnt, it.cnt);
`else
      if (bad) $display("FAIL %s @cyc %0d: sel/div/ack/busy/err got %b want %b",
                        it.name, cyc, got, it.exp);
`endif
      n_vec++;
      if (bad) n_err++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge hsclk_in);
    #1;
  endtask

  initial begin
    // Reset, then idle in SLOW with fast mode disabled.
    tick(2);  expect_now("reset_state", 5'b00100, 0);
    tick(1);  rst_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(20); expect_now("slow_idle", 5'b00100, 0);
    end

    // Enable fast mode; one host cycle restarts the 16-cycle hold-off.
    fast_en = 1'b1; slow_req = 1'b1; div_sel_req = 1'b1;
    tick(1);  slow_req = 1'b0;
    tick(16); expect_now("hold_not_expired", 5'b00100);
    tick(1);  expect_now("enter_to_fast", 5'b11010);
    tick(6);  expect_now("await_hs_sync", 5'b11010);
    tick(1);  expect_now("arrive_fast", 5'b11000, 1);

    // Divider request is ignored while FAST.
    div_sel_req = 1'b0;
    tick(3);  expect_now("div_frozen_in_fast", 5'b11000);

    // Host access: drop to slow, ack after feedback syncs, re-fast after hold.
    slow_req = 1'b1;
    tick(1);  expect_now("slow_req_drops_sel", 5'b01010);
    tick(6);  expect_now("await_ls_sync", 5'b01010);
    tick(1);  expect_now("slow_ack_rise", 5'b01100);
    tick(3);  slow_req = 1'b0;
    tick(16); expect_now("rehold", 5'b01100);
    tick(1);  expect_now("refast_new_div", 5'b10010);

    // fast_en drops during TO_FAST: complete to FAST, leave next cycle.
    fast_en = 1'b0;
    tick(6);  expect_now("fast_en_low_in_to_fast", 5'b10010);
    tick(1);  expect_now("completes_to_fast", 5'b10000, 2);
    tick(1);  expect_now("leaves_fast", 5'b00010);
    tick(6);  expect_now("await_ls_sync2", 5'b00010);
    tick(1);  expect_now("back_slow", 5'b00100);

    // Dead switcher: TO_FAST times out, then TO_SLOW times out with err_clr coincident.
    dead = 1'b1; fast_en = 1'b1;
    tick(16);  expect_now("hold_dead", 5'b00100);
    tick(1);   expect_now("to_fast_dead", 5'b10010);
    tick(254); expect_now("pre_timeout", 5'b10010);
    tick(1);   expect_now("timeout_to_fast", 5'b00011);
    tick(254); err_clr = 1'b1;
    tick(1);   err_clr = 1'b0; expect_now("set_beats_clear", 5'b00011);
    tick(1);   expect_now("err_sticky", 5'b00011);
    dead = 1'b0;
    tick(2);   expect_now("recover_sync", 5'b00011);
    tick(1);   expect_now("slow_with_err", 5'b00101);
    tick(41);  expect_now("blocked_by_err", 5'b00101);
    err_clr = 1'b1;
    tick(1);   err_clr = 1'b0; expect_now("err_cleared", 5'b00100);
    tick(1);   expect_now("to_fast_after_clr", 5'b10010);
    tick(7);   expect_now("fast_third", 5'b10000, 3);

    // Reset asserted in the middle of a TO_FAST handshake.
    slow_req = 1'b1;
    tick(1);  expect_now("leave_third", 5'b00010);
    tick(7);  expect_now("slow_again", 5'b00100);
    slow_req = 1'b0;
    tick(17); expect_now("to_fast_fourth", 5'b10010, 3);
    tick(2);  rst_b = 1'b0; expect_now("async_reset", 5'b00100, 0);
    tick(2);  rst_b = 1'b1;
    tick(1);  expect_now("post_reset", 5'b00100, 0);

    tick(2);
    @(negedge hsclk_in);
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
      n_vec++;
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
